// File: rtl/muldiv_ctrl_if.sv
// Pipeline-facing bundle of the shared multiply/divide unit: slot requests, operands,
// flush/readback controls and the HI/LO, stall and status outputs.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             req0;
  logic [1:0]       op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             rd_hilo;
  logic             flush;
  logic             grant0;
  logic             grant1;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, rd_hilo, flush,
    input  grant0, grant1, stall, busy, done, hi, lo
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, rd_hilo, flush,
    output grant0, grant1, stall, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Shared iterative multiply/divide sequencer for both issue slots; owns HI/LO.
// Signed ops run on magnitudes and fix the signs up in a final cycle.
//
// state | meaning
// IDLE  | accepting requests (slot 0 priority), HI/LO stable
// MUL   | WIDTH shift-add iterations on operand magnitudes
// DIV   | WIDTH restoring-divide iterations on operand magnitudes
// FIX   | sign fix-up / divide-by-zero override, HI/LO written at closing edge
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] raw_a_q, raw_a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             grant0, grant1, take, busy;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b, mag_a, mag_b;
  logic             sel_signed;
  logic [WIDTH:0]   mul_sum, div_shift, div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    grant0     = (state_q == IDLE) & ~bus.flush & bus.req0;
    grant1     = (state_q == IDLE) & ~bus.flush & ~bus.req0 & bus.req1;
    take       = grant0 | grant1;
    sel_op     = grant0 ? bus.op0 : bus.op1;
    sel_a      = grant0 ? bus.a0 : bus.a1;
    sel_b      = grant0 ? bus.b0 : bus.b1;
    sel_signed = ~sel_op[0];
    mag_a      = (sel_signed & sel_a[WIDTH-1]) ? -sel_a : sel_a;
    mag_b      = (sel_signed & sel_b[WIDTH-1]) ? -sel_b : sel_b;
  end

  // Multiply keeps {acc,q} as the running product with the multiplier shifting out of q;
  // divide shifts the dividend out of q into the partial remainder acc.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (q_q[0] ? b_q : {WIDTH{1'b0}})};
    div_shift = {acc_q, q_q[WIDTH-1]};
    div_sub   = div_shift - {1'b0, b_q};
    prod_fix  = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
    quo_fix   = neg_q ? -q_q : q_q;
    rem_fix   = neg_rem_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    b_d       = b_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d   = sel_op[1] ? DIV : MUL;
          cnt_d     = CW'(WIDTH - 1);
          acc_d     = '0;
          q_d       = mag_a;
          b_d       = mag_b;
          raw_a_d   = sel_a;
          is_div_d  = sel_op[1];
          neg_d     = sel_signed & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
          neg_rem_d = sel_signed & sel_a[WIDTH-1];
          dz_d      = (sel_b == '0);
        end
      end
      MUL: begin
        acc_d = mul_sum[WIDTH:1];
        q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DIV: begin
        acc_d = div_sub[WIDTH] ? div_shift[WIDTH-1:0] : div_sub[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~div_sub[WIDTH]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = raw_a_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including the HI/LO write in FIX.
    if (bus.flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      b_q       <= b_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign bus.grant0 = grant0;
  assign bus.grant1 = grant1;
  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.stall  = (busy & (bus.req0 | bus.req1 | bus.rd_hilo)) |
                      (~busy & bus.req0 & bus.req1);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_muldiv_ctrl;
  localparam int W = 32;
  localparam int LAT = W + 2;
  localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();
  muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mh, output logic [W-1:0] ml);
    longint     sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mh = '0;
    ml = '0;
    case (op)
      OP_MULT: begin p = sa * sb; {mh, ml} = p; end
      OP_MULTU: begin up = {32'h0, a} * {32'h0, b}; {mh, ml} = up; end
      OP_DIV: begin
        if (b == 0) begin ml = '1; mh = a; end
        else begin q = sa / sb; r = sa % sb; ml = q[W-1:0]; mh = r[W-1:0]; end
      end
      default: begin
        if (b == 0) begin ml = '1; mh = a; end
        else begin ml = a / b; mh = a % b; end
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [5];
    edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return $urandom();
  endfunction

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    bus.rd_hilo = 0; bus.flush = 0;
  endtask

  // Issues one op from a slot; returns grant seen, cycles until done (-1 on timeout) and HI/LO then.
  task automatic do_op(input bit slot, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit g, output int lat, output logic [W-1:0] oh, output logic [W-1:0] ol);
    @(negedge clk);
    if (slot) begin bus.req1 = 1; bus.op1 = op; bus.a1 = a; bus.b1 = b; end
    else      begin bus.req0 = 1; bus.op0 = op; bus.a0 = a; bus.b0 = b; end
    #1 g = slot ? bus.grant1 : bus.grant0;
    lat = -1; oh = '0; ol = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.req0 = 0; bus.req1 = 0;
      #1;
      if (bus.done === 1'b1) begin lat = n; oh = bus.hi; ol = bus.lo; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_vec++; if (bus.hi !== '0 || bus.lo !== '0) begin n_err++; $display("FAIL reset_hilo got %h_%h exp 0_0", bus.hi, bus.lo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]   ops [6];
    logic [W-1:0] as [6];
    logic [W-1:0] bs [6];
    logic [W-1:0] eh [6];
    logic [W-1:0] el [6];
    logic [W-1:0] oh, ol;
    bit g; int lat;
    ops = '{OP_MULT, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU};
    as  = '{32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'h12345678, 32'h80000000, 32'hABCD0000};
    bs  = '{32'd5, 32'd7, 32'd2, 32'h0, 32'hFFFFFFFF, 32'h0};
    eh  = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'h12345678, 32'h0, 32'hABCD0000};
    el  = '{32'hFFFFFFF1, 32'hE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, ops[i], as[i], bs[i], g, lat, oh, ol);
      n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL dir_grant i=%0d got %b exp 1", i, g); end
      n_vec++; if (lat != LAT) begin n_err++; $display("FAIL dir_latency i=%0d got %0d exp %0d", i, lat, LAT); end
      n_vec++; if (oh !== eh[i] || ol !== el[i]) begin
        n_err++; $display("FAIL dir_hilo i=%0d got %h_%h exp %h_%h", i, oh, ol, eh[i], el[i]);
      end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width got %b exp 0", bus.done); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eh, el, oh, ol;
    logic [1:0] op;
    bit slot, g; int lat;
    for (int i = 0; i < 40; i++) begin
      slot = 1'($urandom_range(1));
      op   = 2'($urandom_range(3));
      a    = pick();
      b    = ($urandom_range(7) == 0) ? '0 : pick();
      model(op, a, b, eh, el);
      do_op(slot, op, a, b, g, lat, oh, ol);
      n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL rand_grant i=%0d slot=%0d got %b exp 1", i, slot, g); end
      n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rand_latency i=%0d got %0d exp %0d", i, lat, LAT); end
      n_vec++; if (oh !== eh || ol !== el) begin
        n_err++; $display("FAIL rand_hilo i=%0d op=%0d a=%h b=%h got %h_%h exp %h_%h", i, op, a, b, oh, ol, eh, el);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] eh, el;
    logic exp_s;
    model(OP_MULT, 32'd7, 32'hFFFFFFF7, eh, el);
    @(negedge clk);
    bus.req0 = 1; bus.op0 = OP_MULT; bus.a0 = 32'd7; bus.b0 = 32'hFFFFFFF7;
    #1;
    n_vec++; if (bus.stall !== 1'b0 || bus.grant0 !== 1'b1) begin
      n_err++; $display("FAIL stall_single_idle got stall=%b grant0=%b exp 0 1", bus.stall, bus.grant0);
    end
    for (int n = 1; n < LAT; n++) begin
      @(negedge clk);
      bus.req0 = 1'($urandom_range(1)); bus.req1 = 1'($urandom_range(1)); bus.rd_hilo = 1'($urandom_range(1));
      #1 exp_s = bus.req0 | bus.req1 | bus.rd_hilo;
      n_vec++; if (bus.stall !== exp_s || bus.grant0 !== 1'b0 || bus.grant1 !== 1'b0 || bus.busy !== 1'b1) begin
        n_err++; $display("FAIL stall_busy n=%0d got stall=%b g=%b%b busy=%b exp stall=%b g=00 busy=1",
                          n, bus.stall, bus.grant0, bus.grant1, bus.busy, exp_s);
      end
    end
    @(negedge clk);
    bus.req0 = 0; bus.req1 = 0; bus.rd_hilo = 1;
    #1;
    n_vec++; if (bus.done !== 1'b1 || bus.stall !== 1'b0) begin
      n_err++; $display("FAIL stall_done_read got done=%b stall=%b exp 1 0", bus.done, bus.stall);
    end
    n_vec++; if (bus.hi !== eh || bus.lo !== el) begin
      n_err++; $display("FAIL stall_done_hilo got %h_%h exp %h_%h", bus.hi, bus.lo, eh, el);
    end
    bus.rd_hilo = 0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eh0, el0, eh1, el1;
    int lat;
    model(OP_MULTU, 32'hDEADBEEF, 32'h12345678, eh0, el0);
    model(OP_DIVU, 32'hDEADBEEF, 32'h00001234, eh1, el1);
    @(negedge clk);
    bus.req0 = 1; bus.op0 = OP_MULTU; bus.a0 = 32'hDEADBEEF; bus.b0 = 32'h12345678;
    bus.req1 = 1; bus.op1 = OP_DIVU;  bus.a1 = 32'hDEADBEEF; bus.b1 = 32'h00001234;
    #1;
    n_vec++; if (bus.grant0 !== 1'b1 || bus.grant1 !== 1'b0 || bus.stall !== 1'b1) begin
      n_err++; $display("FAIL b2b_arb got g0=%b g1=%b stall=%b exp 1 0 1", bus.grant0, bus.grant1, bus.stall);
    end
    for (int n = 1; n < LAT; n++) begin
      @(negedge clk);
      bus.req0 = 0;
      #1;
      n_vec++; if (bus.stall !== 1'b1 || bus.grant1 !== 1'b0) begin
        n_err++; $display("FAIL b2b_hold n=%0d got stall=%b g1=%b exp 1 0", n, bus.stall, bus.grant1);
      end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.done !== 1'b1 || bus.grant1 !== 1'b1 || bus.stall !== 1'b0) begin
      n_err++; $display("FAIL b2b_handoff got done=%b g1=%b stall=%b exp 1 1 0", bus.done, bus.grant1, bus.stall);
    end
    n_vec++; if (bus.hi !== eh0 || bus.lo !== el0) begin
      n_err++; $display("FAIL b2b_slot0_hilo got %h_%h exp %h_%h", bus.hi, bus.lo, eh0, el0);
    end
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      bus.req1 = 0;
      #1;
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    n_vec++; if (lat != LAT || bus.hi !== eh1 || bus.lo !== el1) begin
      n_err++; $display("FAIL b2b_slot1 got lat=%0d %h_%h exp lat=%0d %h_%h", lat, bus.hi, bus.lo, LAT, eh1, el1);
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] oh, ol, ph, pl;
    bit g, saw_done; int lat;
    do_op(1'b0, OP_MULT, 32'hFFFFFFFD, 32'd5, g, lat, oh, ol);
    ph = bus.hi; pl = bus.lo;
    // flush during the iterate phase
    @(negedge clk);
    bus.req0 = 1; bus.op0 = OP_MULTU; bus.a0 = 32'h11111111; bus.b0 = 32'h22222222;
    for (int n = 1; n <= 10; n++) begin @(negedge clk); bus.req0 = 0; end
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_mid_busy got %b exp 0", bus.busy); end
    saw_done = 0;
    repeat (40) begin @(negedge clk); #1; if (bus.done === 1'b1) saw_done = 1; end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL flush_mid_nodone got %b exp 0", saw_done); end
    n_vec++; if (bus.hi !== ph || bus.lo !== pl) begin
      n_err++; $display("FAIL flush_mid_hilo got %h_%h exp %h_%h", bus.hi, bus.lo, ph, pl);
    end
    // flush with a request in IDLE
    @(negedge clk);
    bus.flush = 1; bus.req0 = 1; bus.op0 = OP_DIVU; bus.a0 = 32'd9; bus.b0 = 32'd3;
    #1;
    n_vec++; if (bus.grant0 !== 1'b0 || bus.grant1 !== 1'b0 || bus.stall !== 1'b0) begin
      n_err++; $display("FAIL flush_idle_grant got g0=%b g1=%b stall=%b exp 0 0 0", bus.grant0, bus.grant1, bus.stall);
    end
    @(negedge clk);
    bus.flush = 0; bus.req0 = 0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy got %b exp 0", bus.busy); end
    // flush landing on the fix-up cycle
    @(negedge clk);
    bus.req0 = 1; bus.op0 = OP_DIVU; bus.a0 = 32'd1000; bus.b0 = 32'd3;
    for (int n = 1; n <= W + 1; n++) begin @(negedge clk); bus.req0 = 0; end
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    #1;
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL flush_fix got done=%b busy=%b exp 0 0", bus.done, bus.busy);
    end
    n_vec++; if (bus.hi !== ph || bus.lo !== pl) begin
      n_err++; $display("FAIL flush_fix_hilo got %h_%h exp %h_%h", bus.hi, bus.lo, ph, pl);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] oh, ol;
    bit g; int lat;
    @(negedge clk);
    bus.req0 = 1; bus.op0 = OP_DIV; bus.a0 = 32'h7654321; bus.b0 = 32'd13;
    for (int n = 1; n <= 15; n++) begin @(negedge clk); bus.req0 = 0; end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL midreset_status got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    n_vec++; if (bus.hi !== '0 || bus.lo !== '0) begin
      n_err++; $display("FAIL midreset_hilo got %h_%h exp 0_0", bus.hi, bus.lo);
    end
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2, g, lat, oh, ol);
    n_vec++; if (g !== 1'b1 || lat != LAT || oh !== 32'hFFFFFFFF || ol !== 32'hFFFFFFFD) begin
      n_err++; $display("FAIL postreset_div got g=%b lat=%0d %h_%h exp 1 %0d FFFFFFFF_FFFFFFFD", g, lat, oh, ol, LAT);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
